logic_sched: RTL and testbench
==============================

# logic_sched

Two-requester scheduler for the shared 32-bit logic unit. It accepts operations from two independent requesters over valid/ready handshakes and grants the unit to one of them. It captures that requester's operands, evaluates the logic function in a registered stage, and returns the result with a requester ID over a single valid/ready response channel. It sits between the instruction-issue paths and the logic datapath, so one logic unit serves both issue paths.

## Interface
Parameters:
- WIDTH, 32, operand and result width; only 32 is supported.

Ports:
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle if valid
- req0_a, req0_b  in  32  requester 0 operands
- req0_funct  in  3  requester 0 function code
- req1_valid, req1_ready, req1_a, req1_b, req1_funct  as above, for requester 1
- resp_valid  out  1  result available
- resp_ready  in  1  consumer takes result this cycle if valid
- resp_data  out  32  result
- resp_id  out  1  requester that issued the result (0/1)
- resp_zero  out  1  resp_data == 0
- busy  out  1  state != IDLE

## Operation
- Function codes for funct[1:0], with funct[2] as the modifier:
  - 00: OR; with funct[2]=1, NOR.
  - 01: AND; with funct[2]=1, NAND.
  - 10: XOR; with funct[2]=1, XNOR.
  - 11: ~a when funct[2]=0; ~b when funct[2]=1.
- FSM states:
  - IDLE: reqN_ready driven for the granted requester only. On acceptance (valid & ready):
    - capture a, b, funct and ID into internal registers;
    - update last_id to the accepted ID;
    - go to EXEC.
  - EXEC: compute from the captured operands. Register resp_data, resp_zero and resp_id, set resp_valid=1, go to DONE.
  - DONE: hold all resp_* outputs stable. On resp_valid & resp_ready, clear resp_valid and go to IDLE.
- Grant, combinational in IDLE:
  - only one valid: grant it;
  - both valid: arbitration per Configuration;
  - none valid: no ready asserted.
- Both readies are 0 outside IDLE and whenever rst=1. At most one ready is high in any cycle.
- Operands are captured at acceptance. The requester may change or deassert them afterwards.
- A requester must hold valid and its operands until accepted. The scheduler never drops an asserted request.
- resp_data, resp_id and resp_zero keep their last value after the handshake until the next EXEC.

## Timing
- Reset (rst=1 at an edge) sets:
  - state to IDLE; busy=0;
  - resp_valid=0, resp_data=0, resp_id=0, resp_zero=0;
  - last_id=1, so requester 0 wins first arbitration.
- Reset mid-operation, in EXEC or DONE, abandons the pending result. No response is issued for it.
- Latency:
  - acceptance at edge E0;
  - EXEC during the next cycle;
  - resp_valid=1 from edge E1 onward, i.e. the second cycle after the acceptance cycle.
- Throughput with resp_ready tied high: one operation per 3 cycles (IDLE, EXEC, DONE). No acceptance overlaps DONE.
- Backpressure: resp_ready=0 holds DONE indefinitely with outputs stable. Requests stall with ready=0.
- A request arriving in EXEC or DONE waits. It is considered in the first IDLE cycle.
- Both requesters valid in the same IDLE cycle: exactly one is accepted. The other stays pending and is served in the next IDLE cycle if still valid.

## Configuration
- LOGIC_SCHED_RR_EN defined: round-robin arbitration. When both requesters are valid, grant !last_id. Neither requester can starve the other.
- LOGIC_SCHED_RR_EN undefined: fixed priority, requester 0 always wins. last_id is still maintained but does not affect the grant.
- All other behaviour is identical in both builds.

## Test plan
- OR: req0 a=0xF0F00000, b=0x0FF00000, funct=000, resp_ready=1.
  - req0_ready=1 in the same cycle;
  - resp_valid rises 2 cycles later with resp_data=0xFFF00000, resp_id=0, resp_zero=0.
- Function sweep on req1 with the same operands, one result per funct:
  - 101 → 0xFF0FFFFF;
  - 010 → 0xFF000000;
  - 011 → 0x0F0FFFFF;
  - 111 → 0xF00FFFFF;
  - every response has resp_id=1.
- Zero flag: a=b=0x12345678, funct=010 → resp_data=0x00000000, resp_zero=1.
- Contention: both requesters valid continuously for 4 operations.
  - With RR_EN: resp_id sequence is 0,1,0,1.
  - Without RR_EN: resp_id sequence is 0,0,0,0.
- Backpressure and reset:
  - hold resp_ready=0 for 5 cycles in DONE → resp_data and resp_id stable, both readies 0;
  - then assert rst for 1 cycle → resp_valid=0, busy=0, resp_data=0;
  - the held result is never delivered.

Source files
------------

// File: rtl/logic_sched.sv
// logic_sched: two-requester scheduler for the shared 32-bit logic unit.
// Arbitrates two valid/ready request channels, captures the winner's
// operands, evaluates the logic function in a registered stage and returns
// the result with the requester ID over one valid/ready response channel.
// Optional feature: define LOGIC_SCHED_RR_EN for round-robin arbitration;
// when undefined, requester 0 has fixed priority.
module logic_sched #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  // Requester 0
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_funct,
  // Requester 1
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_funct,
  // Response
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_id,
  output logic             resp_zero,
  output logic             busy
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e           state_q, state_d;

  // Captured operation
  logic [WIDTH-1:0] a_q, b_q;
  logic [2:0]       funct_q;
  logic             id_q;
  logic             last_id_q;

  // Response registers
  logic             resp_valid_q;
  logic [WIDTH-1:0] resp_data_q;
  logic             resp_id_q;
  logic             resp_zero_q;

  // Arbitration results
  logic             grant_valid;
  logic             grant_id;
  logic             accept;

  // Selected request fields of the granted requester
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [2:0]       sel_funct;

  logic [WIDTH-1:0] result;

  // Logic function: funct[1:0] selects the operation, funct[2] modifies it.
  function automatic logic [WIDTH-1:0] logic_eval(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic [2:0]       funct);
    logic [WIDTH-1:0] r;
    unique case (funct[1:0])
      2'b00:   r = funct[2] ? ~(a | b) : (a | b);
      2'b01:   r = funct[2] ? ~(a & b) : (a & b);
      2'b10:   r = funct[2] ? ~(a ^ b) : (a ^ b);
      default: r = funct[2] ? ~b : ~a;
    endcase
    return r;
  endfunction

  // Grant selection among the currently valid requesters.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_valid = 1'b1;
`ifdef LOGIC_SCHED_RR_EN
      // Alternate away from the last served requester.
      grant_id    = ~last_id_q;
`else
      grant_id    = 1'b0;
`endif
    end else if (req0_valid) begin
      grant_valid = 1'b1;
      grant_id    = 1'b0;
    end else if (req1_valid) begin
      grant_valid = 1'b1;
      grant_id    = 1'b1;
    end
  end

  // Readies only in IDLE and never while reset is asserted; at most one high.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if ((state_q == StIdle) && !rst && grant_valid) begin
      req0_ready = ~grant_id;
      req1_ready = grant_id;
    end
  end

  assign accept = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  // Operand mux for the accepted requester.
  always_comb begin
    sel_a     = req0_a;
    sel_b     = req0_b;
    sel_funct = req0_funct;
    if (grant_id) begin
      sel_a     = req1_a;
      sel_b     = req1_b;
      sel_funct = req1_funct;
    end
  end

  assign result = logic_eval(a_q, b_q, funct_q);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StExec;
      StExec: state_d = StDone;
      StDone: if (resp_valid_q && resp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Capture operands and requester ID on acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      funct_q   <= 3'b000;
      id_q      <= 1'b0;
      last_id_q <= 1'b1;
    end else if (accept) begin
      a_q       <= sel_a;
      b_q       <= sel_b;
      funct_q   <= sel_funct;
      id_q      <= grant_id;
      last_id_q <= grant_id;
    end
  end

  // Response registers: loaded in EXEC, held through DONE and afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_id_q    <= 1'b0;
      resp_zero_q  <= 1'b0;
    end else if (state_q == StExec) begin
      resp_valid_q <= 1'b1;
      resp_data_q  <= result;
      resp_id_q    <= id_q;
      resp_zero_q  <= (result == '0);
    end else if ((state_q == StDone) && resp_valid_q && resp_ready) begin
      resp_valid_q <= 1'b0;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_id    = resp_id_q;
  assign resp_zero  = resp_zero_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_logic_sched.sv
// Scoreboard bench for logic_sched: stimulus pushes expected responses,
// a negedge monitor pops and compares on each response handshake.
module tb_logic_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready;
  logic [31:0] req0_a, req0_b;
  logic [2:0]  req0_funct;
  logic        req1_valid, req1_ready;
  logic [31:0] req1_a, req1_b;
  logic [2:0]  req1_funct;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_data;
  logic        resp_id, resp_zero, busy;

  typedef struct packed {
    logic [31:0] data;
    logic        id;
    logic        zero;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  logic_sched #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_funct (req0_funct),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_funct (req1_funct),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .resp_zero  (resp_zero),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, want);
  endtask

  task automatic push(input logic [31:0] data, input logic id);
    exp_t e;
    e.data = data;
    e.id   = id;
    e.zero = (data == 32'h0);
    exp_q.push_back(e);
  endtask

  // Monitor: compare every delivered response against the scoreboard.
  always @(negedge clk) begin
    if (!rst && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", {31'd0, resp_valid}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("resp_data", resp_data, e.data);
        check("resp_id", {31'd0, resp_id}, {31'd0, e.id});
        check("resp_zero", {31'd0, resp_zero}, {31'd0, e.zero});
      end
    end
  end

  // Issue one request; call just after a posedge. Returns just after the accepting edge.
  task automatic send(input logic id, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] f);
    int  cyc  = 0;
    bit  done = 0;
    if (id == 1'b0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_funct = f;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_funct = f;
    end
    while (!done && cyc < 50) begin
      @(negedge clk);
      if ((id == 1'b0 && req0_ready) || (id == 1'b1 && req1_ready)) done = 1;
      @(posedge clk); #1;
      cyc++;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (!done) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    int cyc = 0;
    @(negedge clk);
    while (busy && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (busy) check("idle_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] held_data;
    logic        held_id;
    int          accepts;
    int          cyc;
    logic        ids [4];

    rst = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_funct = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_funct = '0;
    resp_ready = 1'b1;

    // Reset state, with a request pending that must not be granted.
    repeat (3) @(posedge clk);
    #1 req0_valid = 1'b1;
    @(negedge clk);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_resp_id", {31'd0, resp_id}, 32'd0);
    check("rst_resp_zero", {31'd0, resp_zero}, 32'd0);
    check("rst_ready0", {31'd0, req0_ready}, 32'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    // OR on req0 with latency check.
    push(32'hFFF00000, 1'b0);
    req0_valid = 1'b1; req0_a = 32'hF0F00000; req0_b = 32'h0FF00000; req0_funct = 3'b000;
    @(negedge clk);
    check("or_ready_same_cycle", {31'd0, req0_ready}, 32'd1);
    check("or_ready1_low", {31'd0, req1_ready}, 32'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    check("lat_exec_valid", {31'd0, resp_valid}, 32'd0);
    check("lat_exec_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("lat_done_valid", {31'd0, resp_valid}, 32'd1);
    wait_idle();

    // Function sweep on req1; back-to-back sends also exercise waiting in EXEC/DONE.
    push(32'hFF0FFFFF, 1'b1); send(1'b1, 32'hF0F00000, 32'h0FF00000, 3'b101);
    push(32'hFF000000, 1'b1); send(1'b1, 32'hF0F00000, 32'h0FF00000, 3'b010);
    push(32'h0F0FFFFF, 1'b1); send(1'b1, 32'hF0F00000, 32'h0FF00000, 3'b011);
    push(32'hF00FFFFF, 1'b1); send(1'b1, 32'hF0F00000, 32'h0FF00000, 3'b111);
    push(32'h00F00000, 1'b1); send(1'b1, 32'hF0F00000, 32'h0FF00000, 3'b001);
    push(32'h000FFFFF, 1'b1); send(1'b1, 32'hF0F00000, 32'h0FF00000, 3'b100);
    push(32'h00FFFFFF, 1'b1); send(1'b1, 32'hF0F00000, 32'h0FF00000, 3'b110);

    // Zero flag.
    push(32'h00000000, 1'b0); send(1'b0, 32'h12345678, 32'h12345678, 3'b010);
    wait_idle();

    // Contention: reset so last_id=1 and requester 0 wins first.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
`ifdef LOGIC_SCHED_RR_EN
    ids = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    ids = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    for (int i = 0; i < 4; i++) push(ids[i] ? 32'h0F000F00 : 32'hAAAAFFFF, ids[i]);
    req0_valid = 1'b1; req0_a = 32'hAAAA0000; req0_b = 32'h0000FFFF; req0_funct = 3'b000;
    req1_valid = 1'b1; req1_a = 32'hFF00FF00; req1_b = 32'h0F0F0F0F; req1_funct = 3'b001;
    accepts = 0;
    cyc = 0;
    while (accepts < 4 && cyc < 100) begin
      @(negedge clk);
      if (req0_ready && req1_ready) check("one_ready", 32'd2, 32'd1);
      if (req0_ready || req1_ready) accepts++;
      @(posedge clk); #1;
      cyc++;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("contention_accepts", accepts, 32'd4);
    wait_idle();

    // Backpressure then reset: the held result must never be delivered.
    resp_ready = 1'b0;
    send(1'b0, 32'h11110000, 32'h00001111, 3'b000);
    cyc = 0;
    @(negedge clk);
    while (!resp_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("bp_valid", {31'd0, resp_valid}, 32'd1);
    held_data = 32'h11111111;
    held_id   = 1'b0;
    @(posedge clk); #1;
    req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_data_stable", resp_data, held_data);
      check("bp_id_stable", {31'd0, resp_id}, {31'd0, held_id});
      check("bp_valid_stable", {31'd0, resp_valid}, 32'd1);
      check("bp_readies", {30'd0, req1_ready, req0_ready}, 32'd0);
    end
    @(posedge clk); #1;
    req1_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_rst_valid", {31'd0, resp_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_data", resp_data, 32'd0);
    check("mid_rst_readies", {30'd0, req1_ready, req0_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    resp_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("no_resp_after_rst", {31'd0, resp_valid}, 32'd0);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
